// File: rtl/dual_slope_seq_pkg.sv
// Shared types and helpers for the dual-slope ADC conversion sequencer.
//   state_t     : sequencer FSM states
//   OVR_CODE    : all-ones code reported on a de-integrate timeout (sliced to CNT_W)
//   ch_width()  : channel-select width for a given channel count (minimum 1)
//   lowest_set(): index of the lowest set bit of a (zero-extended) channel mask
//   next_set()  : index of the next set bit strictly above a given channel
package dual_slope_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    INTEGRATE,
    DEINTEGRATE,
    STORE,
    DISCHARGE
  } state_t;

  localparam logic [31:0] OVR_CODE = 32'hFFFF_FFFF;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } ch_search_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Descending scan so the lowest set bit is the last one written.
  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic ch_search_t next_set(input logic [15:0] mask, input logic [3:0] cur);
    ch_search_t r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dual_slope_seq_if.sv
// Control/front-end bundle of the dual-slope sequencer.
//   master : register block + analog front end side (drives trigger, mode, mask,
//            ready, comparator, interrupt clear; observes switches and results)
//   slave  : the sequencer itself
interface dual_slope_seq_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 10
);
  import dual_slope_seq_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic             trigger_i;
  logic             continuous_i;
  logic [N_CH-1:0]  ch_mask_i;
  logic             analog_ready_i;
  logic             comp_i;
  logic             interrupt_clear_i;
  logic [CH_W-1:0]  ch_sel_o;
  logic             integrate_o;
  logic             deintegrate_o;
  logic             discharge_o;
  logic [CNT_W-1:0] result_o;
  logic [CH_W-1:0]  result_ch_o;
  logic             result_valid_o;
  logic             overrange_o;
  logic             busy_o;
  logic             interrupt_o;

  modport master (
    output trigger_i, continuous_i, ch_mask_i, analog_ready_i, comp_i, interrupt_clear_i,
    input  ch_sel_o, integrate_o, deintegrate_o, discharge_o, result_o, result_ch_o,
           result_valid_o, overrange_o, busy_o, interrupt_o
  );

  modport slave (
    input  trigger_i, continuous_i, ch_mask_i, analog_ready_i, comp_i, interrupt_clear_i,
    output ch_sel_o, integrate_o, deintegrate_o, discharge_o, result_o, result_ch_o,
           result_valid_o, overrange_o, busy_o, interrupt_o
  );

endinterface

// File: rtl/dual_slope_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset (both flops load RST_VAL)
//   d_i   : asynchronous input
//   q_o   : synchronised output, two clk_i cycles of latency
module dual_slope_seq_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/dual_slope_seq.sv
// Multi-channel dual-slope ADC conversion sequencer.
//   clk_i : system clock
//   rst_i : asynchronous active-high reset
//   bus   : dual_slope_seq_if.slave -- trigger/mode/mask/ready/comparator/irq-clear
//           in; mux select, integrator switches, result stream, busy, interrupt out
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for trigger with a non-zero mask
// SETTLE      | mux switched, waiting for analog_ready
// INTEGRATE   | integrate switch closed for INT_CYCLES clocks
// DEINTEGRATE | reference applied, counting while comparator stays high
// STORE       | one-cycle result strobe
// DISCHARGE   | integrator reset for DISCH_CYCLES clocks, then next channel
module dual_slope_seq
  import dual_slope_seq_pkg::*;
#(
  parameter int CNT_W        = 10,
  parameter int N_CH         = 4,
  parameter int INT_CYCLES   = 255,
  parameter int DISCH_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dual_slope_seq_if.slave  bus
);

  localparam int CH_W   = ch_width(N_CH);
  localparam int DIS_W  = $clog2(DISCH_CYCLES + 1);
  localparam int TMR_W  = (CNT_W > DIS_W) ? CNT_W : DIS_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = OVR_CODE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  state_t           state;
  logic [N_CH-1:0]  mask_q;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] cnt;
  logic             comp_s;
  logic [3:0]       first_in;
  ch_search_t       nxt;

  dual_slope_seq_sync_2ff #(.RST_VAL(1'b0)) u_comp_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.comp_i),
    .q_o   (comp_s)
  );

  // Lowest channel of the live mask (sweep start) and next channel of the latched mask.
  assign first_in = lowest_set(16'(bus.ch_mask_i));
  assign nxt      = next_set(16'(mask_q), 4'(bus.ch_sel_o));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      mask_q             <= '0;
      tmr                <= '0;
      cnt                <= '0;
      bus.ch_sel_o       <= '0;
      bus.integrate_o    <= 1'b0;
      bus.deintegrate_o  <= 1'b0;
      bus.discharge_o    <= 1'b0;
      bus.result_o       <= '0;
      bus.result_ch_o    <= '0;
      bus.result_valid_o <= 1'b0;
      bus.overrange_o    <= 1'b0;
      bus.busy_o         <= 1'b0;
      bus.interrupt_o    <= 1'b0;
    end else begin
      bus.result_valid_o <= 1'b0;
      // A sweep-done set later in this block overrides the clear.
      if (bus.interrupt_clear_i) bus.interrupt_o <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.trigger_i && (bus.ch_mask_i != '0)) begin
            mask_q       <= bus.ch_mask_i;
            bus.ch_sel_o <= CH_W'(first_in);
            bus.busy_o   <= 1'b1;
            state        <= SETTLE;
          end
        end

        SETTLE: begin
          if (bus.analog_ready_i) begin
            bus.integrate_o <= 1'b1;
            tmr             <= TMR_W'(INT_CYCLES - 1);
            state           <= INTEGRATE;
          end
        end

        INTEGRATE: begin
          if (tmr == '0) begin
            bus.integrate_o   <= 1'b0;
            bus.deintegrate_o <= 1'b1;
            cnt               <= '0;
            state             <= DEINTEGRATE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        // Raw count includes the synchroniser latency.
        DEINTEGRATE: begin
          if (!comp_s) begin
            bus.deintegrate_o  <= 1'b0;
            bus.result_o       <= cnt;
            bus.result_ch_o    <= bus.ch_sel_o;
            bus.overrange_o    <= 1'b0;
            bus.result_valid_o <= 1'b1;
            state              <= STORE;
          end else if (cnt == CNT_LAST) begin
            bus.deintegrate_o  <= 1'b0;
            bus.result_o       <= CNT_MAX;
            bus.result_ch_o    <= bus.ch_sel_o;
            bus.overrange_o    <= 1'b1;
            bus.result_valid_o <= 1'b1;
            state              <= STORE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STORE: begin
          bus.discharge_o <= 1'b1;
          tmr             <= TMR_W'(DISCH_CYCLES - 1);
          state           <= DISCHARGE;
        end

        DISCHARGE: begin
          if (tmr == '0) begin
            bus.discharge_o <= 1'b0;
            if (nxt.found) begin
              bus.ch_sel_o <= CH_W'(nxt.idx);
              state        <= SETTLE;
            end else begin
              bus.interrupt_o <= 1'b1;
              if (bus.continuous_i && (bus.ch_mask_i != '0)) begin
                mask_q       <= bus.ch_mask_i;
                bus.ch_sel_o <= CH_W'(first_in);
                state        <= SETTLE;
              end else begin
                bus.busy_o <= 1'b0;
                state      <= IDLE;
              end
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_slope_seq.sv
// Directed bench for dual_slope_seq (N_CH=4, CNT_W=10, INT_CYCLES=255, DISCH_CYCLES=8).
module tb_dual_slope_seq;

  typedef struct {
    int ch;
    int val;
    bit ovr;
  } res_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  res_t res_q[$];
  int   fall_by_ch[4];
  int   last_int_len;
  int   last_dis_len;
  bit   excl_err;
  bit   dbl_valid;

  dual_slope_seq_if #(.N_CH(4), .CNT_W(10)) bus ();

  dual_slope_seq #(
    .CNT_W(10), .N_CH(4), .INT_CYCLES(255), .DISCH_CYCLES(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trigger();
    bus.trigger_i = 1'b1;
    step(1);
    bus.trigger_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.busy_o && n < budget) begin
      step(1);
      n++;
    end
    if (bus.busy_o) check_val({tag, "_timeout"}, 32'(bus.busy_o), 0);
  endtask

  task automatic check_res(input int idx, input int ch, input int val, input bit ovr);
    if (idx < res_q.size()) begin
      check_val($sformatf("res%0d_ch", idx), res_q[idx].ch, ch);
      check_val($sformatf("res%0d_val", idx), res_q[idx].val, val);
      check_val($sformatf("res%0d_ovr", idx), 32'(res_q[idx].ovr), 32'(ovr));
    end else begin
      check_val($sformatf("res%0d_present", idx), res_q.size(), idx + 1);
    end
  endtask

  // Comparator model: high except from DEINTEGRATE cycle fall_by_ch[ch] onward.
  initial begin
    int k;
    int f;
    k = 0;
    bus.comp_i = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.deintegrate_o) begin
        f = fall_by_ch[bus.ch_sel_o];
        bus.comp_i = (f < 0 || k < f) ? 1'b1 : 1'b0;
        k++;
      end else begin
        k = 0;
        bus.comp_i = 1'b1;
      end
    end
  end

  // Result collector and switch-timing monitor.
  initial begin
    int   int_run;
    int   dis_run;
    bit   prev_valid;
    res_t r;
    int_run = 0;
    dis_run = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        int_run = 0;
        dis_run = 0;
        prev_valid = 1'b0;
      end else begin
        if (bus.result_valid_o) begin
          r.ch  = int'(bus.result_ch_o);
          r.val = int'(bus.result_o);
          r.ovr = bus.overrange_o;
          res_q.push_back(r);
        end
        if (bus.result_valid_o && prev_valid) dbl_valid = 1'b1;
        prev_valid = bus.result_valid_o;
        if (int'(bus.integrate_o) + int'(bus.deintegrate_o) + int'(bus.discharge_o) > 1)
          excl_err = 1'b1;
        if (bus.integrate_o) int_run++;
        else if (int_run != 0) begin
          last_int_len = int_run;
          int_run = 0;
        end
        if (bus.discharge_o) dis_run++;
        else if (dis_run != 0) begin
          last_dis_len = dis_run;
          dis_run = 0;
        end
      end
    end
  end

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    excl_err = 1'b0;
    dbl_valid = 1'b0;
    last_int_len = 0;
    last_dis_len = 0;
    fall_by_ch = '{100, 100, 100, 100};
    rst = 1'b1;
    bus.trigger_i = 1'b0;
    bus.continuous_i = 1'b0;
    bus.ch_mask_i = 4'b0000;
    bus.analog_ready_i = 1'b0;
    bus.interrupt_clear_i = 1'b0;

    // Reset state
    step(3);
    rst = 1'b0;
    step(1);
    check_val("rst_busy", 32'(bus.busy_o), 0);
    check_val("rst_switches", {bus.integrate_o, bus.deintegrate_o, bus.discharge_o}, 0);
    check_val("rst_result", {bus.result_o, bus.result_ch_o, bus.result_valid_o, bus.overrange_o}, 0);
    check_val("rst_irq", 32'(bus.interrupt_o), 0);
    check_val("rst_ch_sel", bus.ch_sel_o, 0);

    // Single shot, mask 0101, comp falls at cycle 100 -> 102 counts per channel
    bus.ch_mask_i = 4'b0101;
    pulse_trigger();
    check_val("t1_busy", 32'(bus.busy_o), 1);
    check_val("t1_ch_sel", bus.ch_sel_o, 0);
    step(3);
    check_val("t1_settle_hold", 32'(bus.integrate_o), 0);
    bus.analog_ready_i = 1'b1;
    wait_idle(2000, "t1");
    check_val("t1_irq", 32'(bus.interrupt_o), 1);
    check_val("t1_nres", res_q.size(), 2);
    check_res(0, 0, 102, 1'b0);
    check_res(1, 2, 102, 1'b0);
    check_val("t1_int_len", last_int_len, 255);
    check_val("t1_dis_len", last_dis_len, 8);
    check_val("t1_result_hold", bus.result_o, 102);

    // Sticky interrupt, then clear
    step(2);
    check_val("irq_sticky", 32'(bus.interrupt_o), 1);
    bus.interrupt_clear_i = 1'b1;
    step(1);
    bus.interrupt_clear_i = 1'b0;
    check_val("irq_cleared", 32'(bus.interrupt_o), 0);

    // Trigger with empty mask is ignored
    bus.ch_mask_i = 4'b0000;
    pulse_trigger();
    check_val("mask0_busy", 32'(bus.busy_o), 0);
    step(2);
    check_val("mask0_busy_later", 32'(bus.busy_o), 0);
    check_val("mask0_ch_sel", bus.ch_sel_o, 2);

    // Overrange on ch0, normal ch1; retrigger + mask change while busy ignored;
    // clear held through sweep completion loses to the set.
    res_q.delete();
    fall_by_ch = '{-1, 10, 100, 100};
    bus.ch_mask_i = 4'b0011;
    pulse_trigger();
    check_val("t2_busy", 32'(bus.busy_o), 1);
    bus.ch_mask_i = 4'b1111;
    step(5);
    pulse_trigger();
    check_val("t2_retrig_ch_sel", bus.ch_sel_o, 0);
    check_val("t2_retrig_busy", 32'(bus.busy_o), 1);
    bus.interrupt_clear_i = 1'b1;
    wait_idle(4000, "t2");
    check_val("t2_irq_set_wins", 32'(bus.interrupt_o), 1);
    bus.interrupt_clear_i = 1'b0;
    step(1);
    check_val("t2_irq_kept", 32'(bus.interrupt_o), 1);
    check_val("t2_nres", res_q.size(), 2);
    check_res(0, 0, 1023, 1'b1);
    check_res(1, 1, 12, 1'b0);

    // Continuous: sweep 1 on 0110, mask changed to 1100 mid-sweep, continuous
    // dropped during sweep 2 -> exactly four results then IDLE.
    bus.interrupt_clear_i = 1'b1;
    step(1);
    bus.interrupt_clear_i = 1'b0;
    res_q.delete();
    fall_by_ch = '{20, 20, 20, 20};
    bus.ch_mask_i = 4'b0110;
    bus.continuous_i = 1'b1;
    pulse_trigger();
    check_val("t3_ch_sel", bus.ch_sel_o, 1);
    bus.ch_mask_i = 4'b1100;
    n = 0;
    while (res_q.size() < 3 && n < 3000) begin
      step(1);
      n++;
    end
    check_val("t3_reach_3", res_q.size(), 3);
    bus.continuous_i = 1'b0;
    wait_idle(3000, "t3");
    step(20);
    check_val("t3_busy", 32'(bus.busy_o), 0);
    check_val("t3_nres", res_q.size(), 4);
    check_res(0, 1, 22, 1'b0);
    check_res(1, 2, 22, 1'b0);
    check_res(2, 2, 22, 1'b0);
    check_res(3, 3, 22, 1'b0);
    check_val("t3_irq", 32'(bus.interrupt_o), 1);

    // Asynchronous reset mid-INTEGRATE, then restart at lowest channel
    res_q.delete();
    bus.ch_mask_i = 4'b0110;
    pulse_trigger();
    n = 0;
    while (!bus.integrate_o && n < 50) begin
      step(1);
      n++;
    end
    check_val("t4_in_integrate", 32'(bus.integrate_o), 1);
    step(10);
    #1 rst = 1'b1;
    #1;
    check_val("t4_async_switches", {bus.integrate_o, bus.deintegrate_o, bus.discharge_o}, 0);
    check_val("t4_async_busy", 32'(bus.busy_o), 0);
    check_val("t4_async_result", {bus.result_o, bus.result_ch_o, bus.overrange_o}, 0);
    check_val("t4_async_irq", 32'(bus.interrupt_o), 0);
    step(1);
    rst = 1'b0;
    step(2);
    pulse_trigger();
    check_val("t4_restart_ch", bus.ch_sel_o, 1);
    check_val("t4_restart_busy", 32'(bus.busy_o), 1);
    wait_idle(2000, "t4");
    check_val("t4_nres", res_q.size(), 2);
    check_res(0, 1, 22, 1'b0);
    check_res(1, 2, 22, 1'b0);

    check_val("switch_exclusive", 32'(excl_err), 0);
    check_val("valid_single_cycle", 32'(dbl_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_slope_seq.md
# dual_slope_seq

Multi-channel dual-slope ADC conversion sequencer, the parametrised successor to the single-channel fsm_in controller. Steps through an enabled-channel mask and runs a settle / integrate / de-integrate / discharge cycle per channel. Measures the de-integration time against a synchronised comparator and streams one result per channel. Raises a sticky sweep-complete interrupt; supports single-shot and continuous modes. Sits between the register block and the analog front end (mux, integrator switches, comparator).

## Interface
- CNT_W, 10: result/de-integrate counter width; timeout at 2**CNT_W-1.
- N_CH, 4: number of analog channels (1..16).
- INT_CYCLES, 255: fixed integration length in clocks (1..2**CNT_W-1).
- DISCH_CYCLES, 8: integrator discharge length in clocks (≥1).

- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- trigger_i  in  1  start a sweep (sampled in IDLE only).
- continuous_i  in  1  restart the sweep automatically on completion.
- ch_mask_i  in  N_CH  enabled channels; latched at sweep start.
- analog_ready_i  in  1  mux/front end settled.
- comp_i  in  1  comparator output, asynchronous; high = integrator above threshold.
- interrupt_clear_i  in  1  clears interrupt_o.
- ch_sel_o  out  $clog2(N_CH) (min 1)  analog mux select.
- integrate_o / deintegrate_o / discharge_o  out  1 each  integrator switch controls; mutually exclusive.
- result_o  out  CNT_W  last conversion count.
- result_ch_o  out  $clog2(N_CH)  channel of result_o.
- result_valid_o  out  1  one-cycle strobe.
- overrange_o  out  1  qualifies result_valid_o: timeout hit.
- busy_o  out  1  high in any state other than IDLE.
- interrupt_o  out  1  sticky sweep-done flag.

## Operation
- States:
  - IDLE → SETTLE on trigger_i=1 with ch_mask_i≠0. Latch the mask; ch_sel_o = lowest set bit.
  - SETTLE → INTEGRATE when analog_ready_i=1.
  - INTEGRATE: integrate_o=1 for exactly INT_CYCLES cycles → DEINTEGRATE.
  - DEINTEGRATE: deintegrate_o=1. Counter starts at 0 and increments each cycle while synchronised comp is 1. Exits on the first cycle synchronised comp=0 (result = count), or when count reaches 2**CNT_W-1 (result = all-ones, overrange). → STORE.
  - STORE: one cycle; result_valid_o=1, result_o/result_ch_o/overrange_o updated. → DISCHARGE.
  - DISCHARGE: discharge_o=1 for DISCH_CYCLES cycles.
    - If a higher enabled channel remains in the latched mask: select the next one → SETTLE.
    - Otherwise the sweep is done: set interrupt_o. Then, if continuous_i=1 and ch_mask_i≠0: re-latch the mask → SETTLE at the lowest channel. Else → IDLE.
- comp_i passes through a 2-flop synchroniser. The resulting 2-cycle skew is included in the raw count and is not compensated here.
- Triggers while busy_o=1 are ignored. ch_mask_i changes mid-sweep take effect only at the next sweep start.
- Deasserting continuous_i mid-sweep: the current sweep completes, then the block returns to IDLE.
- interrupt_o: if set and interrupt_clear_i are active in the same cycle, set wins.
- result_o, result_ch_o and overrange_o hold their values until the next STORE.

## Timing
- Reset values: all outputs 0, state IDLE, mask register 0, synchroniser flops 0.
- Reset is asynchronous; assertion mid-conversion drops all switch controls to 0 immediately.
- Trigger sampled in cycle t → busy_o=1 and ch_sel_o valid at t+1.
- INTEGRATE occupies exactly INT_CYCLES cycles.
- If comp_i falls at cycle f of DEINTEGRATE, the synchronised comp falls at f+2, so result = f+2 counts (f counted from 0).
- STORE follows DEINTEGRATE exit by one cycle; result_valid_o is never asserted for two consecutive cycles.
- interrupt_o rises in the cycle after the final DISCHARGE cycle. Clearing takes effect the cycle after interrupt_clear_i.
- No two switch controls are ever high in the same cycle. There is at least one cycle of all-low between INTEGRATE and DEINTEGRATE is not required; the transition is direct.

## Structure
- dual_slope_seq_pkg:
  - state enum (IDLE, SETTLE, INTEGRATE, DEINTEGRATE, STORE, DISCHARGE)
  - CH_W localparam helper function
  - overrange constant.
- Sub-module sync_2ff for comp_i (reusable; reset value parameter).
- Lowest-set-bit / next-set-bit channel search is a function in the package.

## Test plan
- N_CH=4, mask=4'b0101, single shot, comp falls 100 cycles into DEINTEGRATE → results for ch 0 then ch 2, each =102, overrange=0; interrupt_o=1 after the ch 2 DISCHARGE; IDLE.
- comp_i held high → result=1023 with overrange_o=1; sequencing continues to the next channel.
- continuous_i=1 for two sweeps, deasserted mid-second sweep → exactly 2 sweeps of results, then IDLE, busy_o=0.
- interrupt_clear_i pulsed in the same cycle as sweep completion → interrupt_o remains 1; a later clear → 0 on the next cycle.
- rst_i asserted mid-INTEGRATE → all outputs 0 asynchronously; trigger after release restarts at the lowest channel.
- trigger_i with mask=0, and trigger_i while busy → ignored; no state change.
